// File: rtl/mux_2to1.sv
// Two-input selector: combinational y, registered y_q, and an optional saturating
// sel-toggle counter built only when MUX_2TO1_STATS_EN is defined.
module mux_2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             sel,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] sel_toggles
);

  // Ternary keeps X-merge semantics: bits where I0 and I1 agree survive an unknown sel.
  assign y = sel ? I1 : I0;

  logic [WIDTH-1:0] y_d;

  always_comb begin
    y_d = y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

`ifdef MUX_2TO1_STATS_EN

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end
    return val + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             sel_q;
  logic             sel_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    sel_d = sel;
    cnt_d = cnt_q;
    if (sel != sel_q) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // sel_q resets to 0, so a high sel on the first clock after reset counts once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_toggles = cnt_q;

`else

  assign sel_toggles = '0;

`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: combinational sweep, registered path, reset,
// toggle counter (expectations follow MUX_2TO1_STATS_EN) and an 8-bit instance.
module tb_mux_2to1;

`ifdef MUX_2TO1_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       i0, i1, sel;
  logic       y, y_q;
  logic [7:0] sel_toggles;

  logic [7:0] i0_8, i1_8, y8, y8_q;
  logic       sel8;
  logic [7:0] sel_toggles8;

  int n_checks;
  int n_fail;

  mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .I0(i0), .I1(i1), .sel(sel), .y(y),
    .clk(clk), .rst_n(rst_n), .y_q(y_q), .sel_toggles(sel_toggles)
  );

  mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .I0(i0_8), .I1(i1_8), .sel(sel8), .y(y8),
    .clk(clk), .rst_n(rst_n), .y_q(y8_q), .sel_toggles(sel_toggles8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [2:0] v;
    logic [7:0] exp_seq;
    exp_seq = 8'b1101_1000;  // bit k = required y for {I0,I1,sel} = k
    for (int k = 0; k < 8; k++) begin
      v = k[2:0];
      i0 = v[2]; i1 = v[1]; sel = v[0];
      #4;
      n_checks++;
      if (y !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL sweep_y[%0d]: got %b expected %b", k, y, exp_seq[k]);
      end
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i0 = 1'b1; i1 = 1'b0; sel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (y_q !== 1'b0) begin
        n_fail++; $display("FAIL reset_y_q[%0d]: got %b expected 0", c, y_q);
      end
      n_checks++;
      if (sel_toggles !== 8'd0) begin
        n_fail++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", c, sel_toggles);
      end
      n_checks++;
      if (y !== 1'b1) begin
        n_fail++; $display("FAIL reset_y[%0d]: got %b expected 1", c, y);
      end
    end
  endtask

  task automatic test_registered();
    rst_n = 1'b1; i0 = 1'b1; i1 = 1'b0; sel = 1'b0;
    tick();
    tick();  // edge N
    n_checks++;
    if (y_q !== 1'b1) begin
      n_fail++; $display("FAIL reg_edge_n: got %b expected 1", y_q);
    end
    sel = 1'b1;
    #1;
    n_checks++;
    if (y !== 1'b0 || y_q !== 1'b1) begin
      n_fail++; $display("FAIL reg_between: got y=%b y_q=%b expected y=0 y_q=1", y, y_q);
    end
    tick();  // edge N+1
    n_checks++;
    if (y_q !== 1'b0) begin
      n_fail++; $display("FAIL reg_edge_n1: got %b expected 0", y_q);
    end
  endtask

  task automatic test_counter_saturate();
    logic [7:0] exp;
    rst_n = 1'b0; sel = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      sel = ~sel;
      tick();
      if (c == 5 || c == 255 || c == 300) begin
        exp = STATS ? ((c > 255) ? 8'd255 : 8'(c)) : 8'd0;
        n_checks++;
        if (sel_toggles !== exp) begin
          n_fail++; $display("FAIL cnt_toggle[%0d]: got %0d expected %0d", c, sel_toggles, exp);
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      sel = ~sel;
      tick();
    end
    exp = STATS ? 8'd255 : 8'd0;
    n_checks++;
    if (sel_toggles !== exp) begin
      n_fail++; $display("FAIL cnt_held_sat: got %0d expected %0d", sel_toggles, exp);
    end
  endtask

  task automatic test_counter_hold();
    logic [7:0] exp;
    rst_n = 1'b0; sel = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sel = ~sel;
      tick();
    end
    for (int c = 0; c < 10; c++) tick();
    exp = STATS ? 8'd3 : 8'd0;
    n_checks++;
    if (sel_toggles !== exp) begin
      n_fail++; $display("FAIL cnt_hold: got %0d expected %0d", sel_toggles, exp);
    end
    // Mid-operation reset coinciding with a sel change: reset wins.
    rst_n = 1'b0; sel = ~sel; i0 = 1'b1; i1 = 1'b1;
    tick();
    n_checks++;
    if (sel_toggles !== 8'd0 || y_q !== 1'b0) begin
      n_fail++; $display("FAIL cnt_reset_wins: got cnt=%0d y_q=%b expected 0 0", sel_toggles, y_q);
    end
    rst_n = 1'b1; sel = 1'b1;
    tick();
    exp = STATS ? 8'd1 : 8'd0;
    n_checks++;
    if (sel_toggles !== exp || y_q !== 1'b1) begin
      n_fail++; $display("FAIL cnt_first_after_reset: got cnt=%0d y_q=%b expected %0d 1",
                         sel_toggles, y_q, exp);
    end
  endtask

  task automatic test_width8();
    logic [7:0] mask;
    i0_8 = 8'hA5; i1_8 = 8'h3C; sel8 = 1'b0;
    #1;
    n_checks++;
    if (y8 !== 8'hA5) begin
      n_fail++; $display("FAIL w8_sel0: got %h expected a5", y8);
    end
    sel8 = 1'b1;
    #1;
    n_checks++;
    if (y8 !== 8'h3C) begin
      n_fail++; $display("FAIL w8_sel1: got %h expected 3c", y8);
    end
    tick();
    n_checks++;
    if (y8_q !== 8'h3C) begin
      n_fail++; $display("FAIL w8_y_q: got %h expected 3c", y8_q);
    end
    // Unknown sel: only bits where A5 and 3C agree (6,5,2,1 -> 0,1,1,0) are defined.
    sel8 = 1'bx;
    mask = 8'b0110_0110;
    #1;
    n_checks++;
    if ((y8 & mask) !== 8'b0010_0100) begin
      n_fail++; $display("FAIL w8_selx: got %b expected agreeing bits x01xx10x", y8);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    clk_en = 1'b0; rst_n = 1'b0;
    i0 = 1'b0; i1 = 1'b0; sel = 1'b0;
    i0_8 = 8'h00; i1_8 = 8'h00; sel8 = 1'b0;
    test_comb_sweep();
    clk_en = 1'b1;
    test_reset();
    test_registered();
    test_counter_saturate();
    test_counter_hold();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
